window_gen_3x3: RTL and testbench



---
 rtl/win3_pkg.sv | 33 +++
 rtl/window_gen_3x3_if.sv | 38 +++
 rtl/win_out_reg.sv | 33 +++
 rtl/window_gen_3x3.sv | 153 +++++++++++++++
 tb/tb_window_gen_3x3.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/win3_pkg.sv
// Shared types and constants for the 3x3 window generator.
// Holds pixel/tap/window widths, FIFO pop threshold, row-tail length,
// the FSM state enum, the registered window payload struct and a
// helper that tests a FIFO fill level against the pop threshold.
package win3_pkg;

    localparam int unsigned PIX_W        = 8;
    localparam int unsigned TAP_W        = 3 * PIX_W;
    localparam int unsigned WIN_W        = 3 * TAP_W;
    localparam int unsigned CNT_W        = 4;
    localparam int unsigned FIFO_POP_MIN = 3;
    localparam int unsigned TAIL_POPS    = 2;
    localparam int unsigned TAIL_W       = $clog2(TAIL_POPS);
    localparam int unsigned STALL_W      = 16;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    typedef struct packed {
        logic             last;
        logic [WIN_W-1:0] data;
    } win_beat_t;

    // A FIFO can supply a full 3-pixel tap once it holds FIFO_POP_MIN pixels.
    function automatic logic fifo_ready(input logic [CNT_W-1:0] cnt);
        return cnt >= CNT_W'(FIFO_POP_MIN);
    endfunction

endpackage

// File: rtl/window_gen_3x3_if.sv
// Row-FIFO and window-output bundle of the 3x3 window generator.
// Signals:
//   row0/1/2_data  : 24-bit taps of the top/middle/bottom row FIFOs
//   row0/1/2_count : fill levels of those FIFOs
//   pop            : common pop to all three FIFOs
//   window_data    : {row2,row1,row0} 3x3 window
//   window_valid / window_ready / window_last : output handshake
// master = window generator, slave = FIFOs plus processing stage.
interface window_gen_3x3_if;
    import win3_pkg::*;

    logic [TAP_W-1:0] row0_data;
    logic [TAP_W-1:0] row1_data;
    logic [TAP_W-1:0] row2_data;
    logic [CNT_W-1:0] row0_count;
    logic [CNT_W-1:0] row1_count;
    logic [CNT_W-1:0] row2_count;
    logic             pop;
    logic [WIN_W-1:0] window_data;
    logic             window_valid;
    logic             window_ready;
    logic             window_last;

    modport master (
        input  row0_data, row1_data, row2_data,
        input  row0_count, row1_count, row2_count,
        input  window_ready,
        output pop, window_data, window_valid, window_last
    );

    modport slave (
        output row0_data, row1_data, row2_data,
        output row0_count, row1_count, row2_count,
        output window_ready,
        input  pop, window_data, window_valid, window_last
    );

endinterface

// File: rtl/win_out_reg.sv
// Single-entry valid/ready output register for window beats.
// Ports: clk, reset_n, load (capture load_beat), load_beat, ready (consumer
// accept), valid, beat (registered payload), slot_free (may load this cycle).
// A load while the current beat is being accepted replaces it with no bubble.
module win_out_reg
    import win3_pkg::*;
(
    input  logic      clk,
    input  logic      reset_n,
    input  logic      load,
    input  win_beat_t load_beat,
    input  logic      ready,
    output logic      valid,
    output win_beat_t beat,
    output logic      slot_free
);

    assign slot_free = !valid || ready;

    // Payload only moves on load, so it holds stable during a stall.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid <= 1'b0;
            beat  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            beat  <= load_beat;
        end else if (ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/window_gen_3x3.sv
// 3x3 window generator: pops three row FIFOs in lockstep and emits
// {row2,row1,row0} windows over valid/ready, one frame per start pulse.
// Ports: clk, reset_n, start, win (window_gen_3x3_if.master: FIFO taps,
// counts, pop, window handshake), busy, done.
// Optional: define WIN3_STALL_CNT_EN to add stall_cycles[15:0], a saturating
// count of valid & !ready cycles, cleared on accepted start.
module window_gen_3x3
    import win3_pkg::*;
#(
    parameter int unsigned IMG_WIDTH  = 16,
    parameter int unsigned IMG_HEIGHT = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    window_gen_3x3_if.master     win,
    output logic                 busy,
    output logic                 done
`ifdef WIN3_STALL_CNT_EN
    ,
    output logic [STALL_W-1:0]   stall_cycles
`endif
);

    localparam int unsigned COL_W    = $clog2(IMG_WIDTH);
    localparam int unsigned ROW_W    = $clog2(IMG_HEIGHT);
    localparam int unsigned COL_LAST = IMG_WIDTH - 3;
    localparam int unsigned ROW_END  = IMG_HEIGHT - 2;

    state_t            state_q, state_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [ROW_W-1:0]  row_q, row_d, row_next;
    logic [TAIL_W-1:0] tail_q, tail_d;
    logic              busy_d, done_d;
    logic              avail, slot_free, fire, pop_c, col_is_last;
    logic              out_valid;
    win_beat_t         load_beat, out_beat;

    // Popping only when all three hold a full tap keeps the rows aligned.
    assign avail = fifo_ready(win.row0_count) & fifo_ready(win.row1_count)
                 & fifo_ready(win.row2_count);

    assign col_is_last = (col_q == COL_W'(COL_LAST));
    assign row_next    = row_q + ROW_W'(1);

    assign load_beat.last = col_is_last;
    assign load_beat.data = {win.row2_data, win.row1_data, win.row0_data};

    // Next-state, counters and pop.
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        tail_d  = tail_q;
        busy_d  = busy;
        done_d  = 1'b0;
        fire    = 1'b0;
        pop_c   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    busy_d  = 1'b1;
                    col_d   = '0;
                    row_d   = '0;
                    tail_d  = '0;
                end
            end
            RUN: begin
                fire  = avail & slot_free;
                pop_c = fire;
                if (fire) begin
                    if (col_is_last) begin
                        col_d   = '0;
                        state_d = DRAIN;
                    end else begin
                        col_d = col_q + COL_W'(1);
                    end
                end
            end
            DRAIN: begin
                // Discard the row tail; runs even while the output stalls.
                pop_c = avail;
                if (avail) begin
                    if (tail_q == TAIL_W'(TAIL_POPS - 1)) begin
                        tail_d  = '0;
                        row_d   = row_next;
                        state_d = (row_next == ROW_W'(ROW_END)) ? DONE : RUN;
                    end else begin
                        tail_d = tail_q + TAIL_W'(1);
                    end
                end
            end
            DONE: begin
                if (!out_valid) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            col_q   <= '0;
            row_q   <= '0;
            tail_q  <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            tail_q  <= tail_d;
            busy    <= busy_d;
            done    <= done_d;
        end
    end

    win_out_reg u_out (
        .clk       (clk),
        .reset_n   (reset_n),
        .load      (fire),
        .load_beat (load_beat),
        .ready     (win.window_ready),
        .valid     (out_valid),
        .beat      (out_beat),
        .slot_free (slot_free)
    );

    assign win.pop          = pop_c;
    assign win.window_valid = out_valid;
    assign win.window_data  = out_beat.data;
    assign win.window_last  = out_beat.last;

`ifdef WIN3_STALL_CNT_EN
    // Saturating back-pressure counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cycles <= '0;
        end else if (state_q == IDLE && start) begin
            stall_cycles <= '0;
        end else if (out_valid && !win.window_ready && stall_cycles != '1) begin
            stall_cycles <= stall_cycles + STALL_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_window_gen_3x3.sv
// Directed bench for window_gen_3x3 (16x16 image). Ideal row FIFOs are modelled
// by a pixel pointer advanced on pop; taps carry pixel=ptr (+16 per row).
// Accepted windows are checked against the expected column sequence.
module tb_window_gen_3x3;
    import win3_pkg::*;

    logic clk;
    logic reset_n;
    logic start;
    logic busy;
    logic done;
`ifdef WIN3_STALL_CNT_EN
    logic [STALL_W-1:0] stall_cycles;
`endif

    window_gen_3x3_if wif ();

    window_gen_3x3 #(
        .IMG_WIDTH  (16),
        .IMG_HEIGHT (16)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .win          (wif),
        .busy         (busy),
        .done         (done)
`ifdef WIN3_STALL_CNT_EN
        ,
        .stall_cycles (stall_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // FIFO model: pixel pointer within the current image row.
    logic [7:0] p;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n)      p <= 8'd0;
        else if (wif.pop)  p <= (p == 8'd15) ? 8'd0 : p + 8'd1;
    end
    assign wif.row0_data = {p + 8'd2,  p + 8'd1,  p};
    assign wif.row1_data = {p + 8'd18, p + 8'd17, p + 8'd16};
    assign wif.row2_data = {p + 8'd34, p + 8'd33, p + 8'd32};

    int checks;
    int errors;
    int exp_col;
    int win_cnt;
    int last_cnt;
    int pop_cnt;
    logic [71:0] held_data;
    logic        held_last;

    function automatic logic [71:0] exp_win(input int c);
        logic [71:0] w;
        w = '0;
        for (int k = 0; k < 3; k++)
            for (int j = 0; j < 3; j++)
                w[(k*3+j)*8 +: 8] = 8'(c + j + 16*k);
        return w;
    endfunction

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // One clock: sample handshake/pop on the negedge, return at posedge+1.
    task automatic tick();
        @(negedge clk);
        if (wif.window_valid && wif.window_ready) begin
            chk("win_data", wif.window_data, exp_win(exp_col));
            chk("win_last", 72'(wif.window_last), 72'(exp_col == 13));
            win_cnt++;
            if (wif.window_last) last_cnt++;
            exp_col = (exp_col == 13) ? 0 : exp_col + 1;
        end
        if (wif.pop) pop_cnt++;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_win(input int n);
        for (int i = 0; i < 2000 && win_cnt < n; i++) tick();
        chk("win_count_reached", 72'(win_cnt >= n), 72'd1);
    endtask

    task automatic clear_mon();
        exp_col  = 0;
        win_cnt  = 0;
        last_cnt = 0;
        pop_cnt  = 0;
    endtask

    task automatic wait_done_and_check();
        for (int i = 0; i < 1000 && done !== 1'b1; i++) tick();
        chk("done_pulse", 72'(done), 72'd1);
        tick();
        chk("done_width", 72'(done), 72'd0);
        chk("busy_after_done", 72'(busy), 72'd0);
        chk("total_windows", 72'(win_cnt), 72'd196);
        chk("total_last", 72'(last_cnt), 72'd14);
        chk("total_pops", 72'(pop_cnt), 72'd224);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        clear_mon();
        reset_n = 1'b0;
        start   = 1'b0;
        wif.window_ready = 1'b0;
        wif.row0_count = 4'd0;
        wif.row1_count = 4'd0;
        wif.row2_count = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 72'(wif.window_valid), 72'd0);
        chk("rst_data", wif.window_data, 72'd0);
        chk("rst_last", 72'(wif.window_last), 72'd0);
        chk("rst_busy", 72'(busy), 72'd0);
        chk("rst_done", 72'(done), 72'd0);
        chk("rst_pop", 72'(wif.pop), 72'd0);

        // Frame 1: first window latency and ramp contents.
        wif.row0_count = 4'd8;
        wif.row1_count = 4'd8;
        wif.row2_count = 4'd8;
        wif.window_ready = 1'b1;
        reset_n = 1'b1;
        tick();
        start = 1'b1;
        #1;
        chk("idle_pop", 72'(wif.pop), 72'd0);
        tick();
        start = 1'b0;
        chk("busy_after_start", 72'(busy), 72'd1);
        chk("valid_before_fire", 72'(wif.window_valid), 72'd0);
        #1;
        chk("first_pop", 72'(wif.pop), 72'd1);
        tick();
        chk("first_valid", 72'(wif.window_valid), 72'd1);
        chk("first_window", wif.window_data, 72'h22_21_20_12_11_10_02_01_00);
        chk("first_last", 72'(wif.window_last), 72'd0);

        // Five-cycle stall mid-row.
        wait_win(5);
        wif.window_ready = 1'b0;
        held_data = wif.window_data;
        held_last = wif.window_last;
        #1;
        chk("stall_pop", 72'(wif.pop), 72'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_data", wif.window_data, held_data);
            chk("stall_last", 72'(wif.window_last), 72'(held_last));
            chk("stall_valid", 72'(wif.window_valid), 72'd1);
            chk("stall_pop", 72'(wif.pop), 72'd0);
        end
        wif.window_ready = 1'b1;
`ifdef WIN3_STALL_CNT_EN
        chk("stall_cycles", 72'(stall_cycles), 72'd5);
`endif

        // Middle FIFO short of a full tap.
        wait_win(20);
        wif.row1_count = 4'd2;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("row1_low_pop", 72'(wif.pop), 72'd0);
            tick();
        end
        wif.row1_count = 4'd8;
        #1;
        chk("row1_restored_pop", 72'(wif.pop), 72'd1);

        // Start while busy is ignored.
        wait_win(40);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_start_ignored", 72'(busy), 72'd1);

        wait_done_and_check();
`ifdef WIN3_STALL_CNT_EN
        chk("stall_cycles_end", 72'(stall_cycles), 72'd5);
`endif

        // Frame 2: reset mid-row, then a full frame.
        clear_mon();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_win(5);
        reset_n = 1'b0;
        #1;
        chk("midrst_valid", 72'(wif.window_valid), 72'd0);
        chk("midrst_data", wif.window_data, 72'd0);
        chk("midrst_last", 72'(wif.window_last), 72'd0);
        chk("midrst_busy", 72'(busy), 72'd0);
        chk("midrst_pop", 72'(wif.pop), 72'd0);
        tick();
        tick();
        clear_mon();
        reset_n = 1'b1;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_frame2", 72'(busy), 72'd1);
        wait_done_and_check();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
